scsi_ic_responder: RTL
======================

# scsi_ic_responder

Synthesizable responder for the SCSI-IC side of the DMA data port: it answers the DMA state machine's DACK/RE/WE/SCSI_CS strobes, raises CDREQ_ when it can source or sink a byte, and returns CDSACK_ after programmable wait states. It holds a small byte FIFO that a target-side stream port fills (SCSI→memory) or drains (memory→SCSI). It is the counterpart of the SCSI transfer state machine. It is used as the bus-accurate SCSI-IC stand-in for system simulation and FPGA loopback bring-up.

## Interface
- DEPTH, 8: byte FIFO depth; power of two, 2..16.
- WAIT_STATES, 1: idle cycles between strobe detection and CDSACK_ assertion; 0..7.
- CLK  in  1  clock.
- nRESET  in  1  asynchronous, active-low reset.
- DMADIR  in  1  0 = SCSI→FIFO (responder sources, RE); 1 = FIFO→SCSI (responder sinks, WE).
- DACK  in  1  data-port acknowledge (DMA cycle).
- SCSI_CS  in  1  register-port chip select (CPU cycle).
- RE  in  1  read strobe.
- WE  in  1  write strobe.
- DIN  in  8  byte written by the initiator.
- DOUT  out  8  byte returned to the initiator.
- CDREQ_  out  1  active-low data request.
- CDSACK_  out  1  active-low cycle acknowledge.
- SRC_VALID / SRC_DATA[7:0] / SRC_READY  in/in/out  target-side load port (bytes to be read by the initiator).
- SNK_VALID / SNK_DATA[7:0] / SNK_READY  out/out/in  target-side drain port (bytes written by the initiator).
- ERR  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- FIFO: DEPTH entries, count 0..DEPTH (width clog2(DEPTH)+1), wrapping read/write pointers.
- Load port: SRC_READY = count<DEPTH. A push occurs on SRC_VALID&SRC_READY.
- Drain port: SNK_VALID = count>0. SNK_DATA = head byte. A pop occurs on SNK_VALID&SNK_READY.
- DMADIR selects which side owns which FIFO end. The load port is active only when DMADIR=0. The drain port is active only when DMADIR=1.
- FSM states:
  - IDLE: strobe cycle starts when (DACK^SCSI_CS)&(RE^WE). The FSM latches kind (DMA/REG), direction, and DMADIR, then goes to WAIT. If WAIT_STATES=0 it goes directly to ACK.
  - WAIT: a wait counter counts down to 0, then → ACK.
  - ACK: the data action happens on entry. CDSACK_=0. Then → RELEASE.
  - RELEASE: CDSACK_ held 0 until RE, WE, DACK, and SCSI_CS are all low, then → IDLE.
- Data action, DMA read (DMADIR=0, RE):
  - DOUT ← head byte and the FIFO pops.
  - If the FIFO is empty: DOUT=8'hFF, no pop, ERR set.
- Data action, DMA write (DMADIR=1, WE):
  - DIN is pushed.
  - If the FIFO is full: the byte is dropped and ERR is set.
- Data action, direction mismatch (RE with DMADIR=1, or WE with DMADIR=0): acked, DOUT=8'h00, FIFO untouched, ERR set.
- Data action, register read (SCSI_CS&RE): DOUT = {DMADIR, 2'b00, count[4:0]}.
- Data action, register write: acked, ignored.
- Illegal strobe (DACK&SCSI_CS, or RE&WE): not started, FSM stays IDLE, ERR set.
- CDREQ_ is registered. It is 0 only when the FSM is IDLE, no strobe is pending, and either:
  - DMADIR=0 and count>0, or
  - DMADIR=1 and count<DEPTH.
- Simultaneous FIFO push and pop in the same cycle are both honoured; count is unchanged.
- A DMADIR change during WAIT, ACK, or RELEASE has no effect on the current cycle, which uses the latched value.

## Timing
- Reset values: DOUT=8'h00, CDREQ_=1, CDSACK_=1, SRC_READY=0, SNK_VALID=0, SNK_DATA=8'h00, ERR=0, FSM=IDLE, count=0, pointers=0.
- SRC_READY and SNK_VALID rise in the first cycle after reset release.
- Strobe sampled at edge n. The FSM enters ACK at edge n+1+WAIT_STATES. CDSACK_ is low and DOUT is valid from that edge.
- CDREQ_ goes high at edge n+1 and stays high through RELEASE.
- Strobes released at edge m: FSM reaches IDLE and CDSACK_=1 at edge m+1. CDREQ_ re-evaluates at edge m+2.
- Minimum DMA cycle length: WAIT_STATES+3 clocks.
- Count updates at the ACK edge. Load-port and drain-port effects are visible in CDREQ_ one cycle later.
- nRESET is asynchronous. Reset mid-cycle aborts the transfer, empties the FIFO, and releases CDSACK_/CDREQ_ immediately.

## Test plan
- Read burst: reset, DMADIR=0, load 8'h11..8'h14, then four DACK+RE cycles → DOUT=8'h11,12,13,14 in order. CDREQ_ rises after the 4th cycle. ERR=0.
- Write burst: DMADIR=1, SNK_READY=0, eight DACK+WE cycles with DIN=8'hA0..8'hA7 → CDREQ_=1 once count=8. A 9th write → byte dropped, ERR=1. Then SNK_READY=1 drains A0..A7.
- Wait states: WAIT_STATES=3, single RE at edge n → CDSACK_ falls at edge n+4. Hold RE 5 extra cycles → CDSACK_ stays low, then rises 1 cycle after release.
- Register read: DMADIR=1, count=5, SCSI_CS+RE → DOUT=8'h85, FIFO untouched.
- Errors: RE on empty FIFO → DOUT=8'hFF, ERR=1. Separately, DACK+SCSI_CS together → no CDSACK_, ERR=1.
- Reset mid-cycle: assert nRESET in WAIT → CDSACK_=1, CDREQ_=1, count=0 immediately. Normal read works after release.

Source files
------------

// File: rtl/scsi_ic_responder.sv
// scsi_ic_responder
//   Bus-accurate SCSI-IC stand-in for the DMA data port. It answers the DMA
//   state machine's DACK/RE/WE/SCSI_CS strobes and requests service on
//   CDREQ_. It acknowledges each cycle on CDSACK_ after WAIT_STATES idle
//   clocks. A small byte FIFO sits between the bus and a target-side stream
//   port: the port fills it when DMADIR=0 and drains it when DMADIR=1.
//
// Ports
//   CLK, nRESET             clock, asynchronous active-low reset
//   DMADIR                  0: SCSI->memory (bus reads), 1: memory->SCSI (bus writes)
//   DACK, SCSI_CS, RE, WE   initiator strobes (DMA / register cycle, read / write)
//   DIN / DOUT              byte from / to the initiator
//   CDREQ_, CDSACK_         active-low data request / cycle acknowledge
//   SRC_VALID/DATA/READY    target-side load port (bytes the initiator will read)
//   SNK_VALID/DATA/READY    target-side drain port (bytes the initiator wrote)
//   ERR                     sticky protocol-error flag, cleared only by reset
module scsi_ic_responder #(
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       DMADIR,
  input  logic       DACK,
  input  logic       SCSI_CS,
  input  logic       RE,
  input  logic       WE,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       CDREQ_,
  output logic       CDSACK_,
  input  logic       SRC_VALID,
  input  logic [7:0] SRC_DATA,
  output logic       SRC_READY,
  output logic       SNK_VALID,
  output logic [7:0] SNK_DATA,
  input  logic       SNK_READY,
  output logic       ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam bit WS0 = (WAIT_STATES == 0);
  localparam logic [2:0] WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]    r_state;
  logic [2:0]    r_wcnt;
  logic          r_is_dma;
  logic          r_is_rd;
  logic          r_dmadir;
  logic          r_dack_s;
  logic          r_cs_s;
  logic          r_re_s;
  logic          r_we_s;
  logic          r_alive;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_dout;
  logic          r_cdreq_n;
  logic          r_err;

  logic          w_idle;
  logic          w_any;
  logic          w_illegal;
  logic          w_start;
  logic          w_enter_ack;
  logic          w_a_dma;
  logic          w_a_rd;
  logic          w_a_dir;
  logic          w_empty;
  logic          w_full;
  logic          w_act_pop;
  logic          w_act_push;
  logic          w_src_ready;
  logic          w_snk_valid;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_push_data;
  logic [7:0]    w_head;
  logic [4:0]    w_cnt5;
  logic          w_err_set;

  // Stage 0: strobe sampling. The FSM only ever looks at these registered copies.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_dack_s <= 1'b0;
      r_cs_s   <= 1'b0;
      r_re_s   <= 1'b0;
      r_we_s   <= 1'b0;
      r_alive  <= 1'b0;
    end else begin
      r_dack_s <= DACK;
      r_cs_s   <= SCSI_CS;
      r_re_s   <= RE;
      r_we_s   <= WE;
      r_alive  <= 1'b1;
    end
  end

  assign w_idle    = (r_state == S_IDLE);
  assign w_any     = r_dack_s | r_cs_s | r_re_s | r_we_s;
  assign w_illegal = (r_dack_s & r_cs_s) | (r_re_s & r_we_s);
  assign w_start   = (r_dack_s ^ r_cs_s) & (r_re_s ^ r_we_s);

  // With zero wait states the data action happens on the same edge that
  // leaves IDLE, before the cycle attributes are latched, so take them live.
  assign w_enter_ack = (w_idle & w_start & WS0) | ((r_state == S_WAIT) & (r_wcnt == 3'd0));
  assign w_a_dma     = w_idle ? r_dack_s : r_is_dma;
  assign w_a_rd      = w_idle ? r_re_s   : r_is_rd;
  assign w_a_dir     = w_idle ? DMADIR   : r_dmadir;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_head  = r_mem[r_rptr];
  assign w_cnt5  = 5'(r_count);

  assign w_act_pop  = w_enter_ack & w_a_dma &  w_a_rd & ~w_a_dir & ~w_empty;
  assign w_act_push = w_enter_ack & w_a_dma & ~w_a_rd &  w_a_dir & ~w_full;

  // A bus cycle uses the latched direction, so the stream port could own the
  // same FIFO end on that edge if DMADIR flipped mid-cycle; the bus wins.
  assign w_src_ready = r_alive & ~DMADIR & ~w_full  & ~w_act_push;
  assign w_snk_valid = r_alive &  DMADIR & ~w_empty & ~w_act_pop;

  assign w_push      = w_act_push | (SRC_VALID & w_src_ready);
  assign w_pop       = w_act_pop  | (w_snk_valid & SNK_READY);
  assign w_push_data = w_act_push ? DIN : SRC_DATA;

  assign w_err_set = (w_idle & w_illegal) |
                     (w_enter_ack & w_a_dma &
                      ((w_a_rd == w_a_dir) |
                       (w_a_rd & w_empty) |
                       (~w_a_rd & w_full)));

  // Stage 1: cycle FSM, FIFO bookkeeping and registered bus outputs.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state   <= S_IDLE;
      r_wcnt    <= 3'd0;
      r_is_dma  <= 1'b0;
      r_is_rd   <= 1'b0;
      r_dmadir  <= 1'b0;
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_dout    <= 8'h00;
      r_cdreq_n <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_is_dma <= r_dack_s;
            r_is_rd  <= r_re_s;
            r_dmadir <= DMADIR;
            r_wcnt   <= WS_INIT;
            r_state  <= WS0 ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wcnt == 3'd0) r_state <= S_ACK;
          else                r_wcnt  <= r_wcnt - 3'd1;
        end
        S_ACK:     r_state <= S_RELEASE;
        default: begin
          if (!w_any) r_state <= S_IDLE;
        end
      endcase

      if (w_enter_ack) begin
        if (w_a_dma) begin
          if (w_a_rd == w_a_dir) r_dout <= 8'h00;
          else if (w_a_rd)       r_dout <= w_empty ? 8'hFF : w_head;
        end else if (w_a_rd) begin
          r_dout <= {w_a_dir, 2'b00, w_cnt5};
        end
      end

      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push & ~w_pop)      r_count <= r_count + CW'(1);
      else if (~w_push & w_pop) r_count <= r_count - CW'(1);

      if (w_err_set) r_err <= 1'b1;

      // Request only from a quiet IDLE; evaluated from pre-edge state, so a
      // new strobe or a count change shows up one clock later.
      r_cdreq_n <= ~(w_idle & ~w_any & (DMADIR ? ~w_full : ~w_empty));
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  assign DOUT      = r_dout;
  assign CDREQ_    = r_cdreq_n;
  assign CDSACK_   = ~((r_state == S_ACK) | (r_state == S_RELEASE));
  assign SRC_READY = w_src_ready;
  assign SNK_VALID = w_snk_valid;
  assign SNK_DATA  = (r_alive & ~w_empty) ? w_head : 8'h00;
  assign ERR       = r_err;

endmodule
